// File: rtl/result_packer_if.sv
// Handshake bundle between the ALU result path (master) and the result packer (slave).
interface result_packer_if #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int OUT_DEPTH     = 2
);
  localparam int SLOTS  = MEM_WORD_SIZE / DATA_W;
  localparam int SEL_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int FILL_W = $clog2(OUT_DEPTH + 1);

  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [DATA_W-1:0]        result_i;
  logic                     addr_mode_i;
  logic [SEL_W-1:0]         slot_sel_i;
  logic                     flush_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [MEM_WORD_SIZE-1:0] out_data_o;
  logic [SLOTS-1:0]         out_mask_o;
  logic [FILL_W-1:0]        fill_o;

  modport master (
    output in_valid_i, result_i, addr_mode_i, slot_sel_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_mask_o, fill_o
  );

  modport slave (
    input  in_valid_i, result_i, addr_mode_i, slot_sel_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_mask_o, fill_o
  );
endinterface

// File: rtl/result_packer.sv
// Packs DATA_W results into MEM_WORD_SIZE words (auto or addressed lanes) and
// queues finished/flushed words with a lane mask in a small output FIFO.
module result_packer_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] merged,
  output logic              merged_set
);
  logic [DATA_W-1:0] q;
  logic              set;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q   <= '0;
      set <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      set <= 1'b0;
    end else if (wr) begin
      q   <= din;
      set <= 1'b1;
    end
  end

  // same-cycle write is visible so a completing or flushed word includes it
  assign merged     = wr ? din : q;
  assign merged_set = set | wr;
endmodule

module result_packer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int OUT_DEPTH     = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  result_packer_if.slave  bus
);
  localparam int SLOTS  = MEM_WORD_SIZE / DATA_W;
  localparam int SEL_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int FILL_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [SEL_W-1:0]  LANE_LAST = SEL_W'(SLOTS - 1);
  localparam logic [PTR_W-1:0]  FIFO_LAST = PTR_W'(OUT_DEPTH - 1);
  localparam logic [FILL_W-1:0] DEPTH_C   = FILL_W'(OUT_DEPTH);

  logic [SEL_W-1:0]              ptr, lane;
  logic                          accept, flush_take, push, pop, clr;
  logic [SLOTS-1:0]              wr, merged_set;
  logic [SLOTS-1:0][DATA_W-1:0]  merged;

  logic [MEM_WORD_SIZE-1:0] mem_d [OUT_DEPTH];
  logic [SLOTS-1:0]         mem_m [OUT_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [FILL_W-1:0]        fill;

  assign bus.in_ready_o = (fill < DEPTH_C);
  assign accept         = bus.in_valid_i & bus.in_ready_o;
  assign flush_take     = bus.flush_i & bus.in_ready_o;
  assign lane           = bus.addr_mode_i ? bus.slot_sel_i : ptr;

  for (genvar k = 0; k < SLOTS; k++) begin : g_lane
    assign wr[k] = accept && (lane == SEL_W'(k));
    result_packer_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr         (wr[k]),
      .clr        (clr),
      .din        (bus.result_i),
      .merged     (merged[k]),
      .merged_set (merged_set[k])
    );
  end

  assign push = (accept && (&merged_set)) || (flush_take && (|merged_set));
  // an empty flush still clears the pointer
  assign clr  = push || flush_take;
  assign pop  = bus.out_valid_o & bus.out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (accept && !bus.addr_mode_i)
      ptr <= (ptr == LANE_LAST) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_m[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr] <= merged;
        mem_m[wr_ptr] <= merged_set;
        wr_ptr        <= (wr_ptr == FIFO_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == FIFO_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  assign bus.fill_o      = fill;
  assign bus.out_valid_o = (fill != '0);
  assign bus.out_data_o  = bus.out_valid_o ? mem_d[rd_ptr] : '0;
  assign bus.out_mask_o  = bus.out_valid_o ? mem_m[rd_ptr] : '0;
endmodule

// File: tb/tb_result_packer.sv
// Randomised + directed bench for result_packer with a queue scoreboard and a
// lane-array reference model; a second 16-bit-lane instance checks 4-lane packing.
module tb_result_packer;
  localparam int DW = 32, MW = 64, DEPTH = 2;
  localparam int SL = MW / DW;
  localparam int SW = (SL > 1) ? $clog2(SL) : 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  result_packer_if #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .OUT_DEPTH(DEPTH)) bus ();
  result_packer #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .OUT_DEPTH(DEPTH)) dut (
    .clk_i (clk_i), .rst_i (rst_i), .bus (bus.slave));

  result_packer_if #(.DATA_W(16), .MEM_WORD_SIZE(64), .OUT_DEPTH(2)) b16 ();
  result_packer #(.DATA_W(16), .MEM_WORD_SIZE(64), .OUT_DEPTH(2)) dut16 (
    .clk_i (clk_i), .rst_i (rst_i), .bus (b16.slave));

  int vectors = 0, errors = 0, got16 = 0;

  // reference model: plain lane arrays, a pointer and an occupancy count
  logic [DW-1:0] mdata [SL];
  bit            mmask [SL];
  int            mptr = 0, mfill = 0;
  logic [MW-1:0] expd [$];
  logic [SL-1:0] expm [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < SL; k++) begin mdata[k] = '0; mmask[k] = 0; end
    mptr = 0;
  endtask

  task automatic model_step();
    bit rdy, pop, acc, fl, full, any, pushed;
    logic [MW-1:0] w;
    logic [SL-1:0] m;
    int lane;
    rdy = mfill < DEPTH;
    pop = (mfill > 0) && bus.out_ready_i;
    acc = bus.in_valid_i && rdy;
    fl  = bus.flush_i && rdy;
    pushed = 0;
    if (acc) begin
      lane = bus.addr_mode_i ? int'(bus.slot_sel_i) : mptr;
      mdata[lane] = bus.result_i;
      mmask[lane] = 1;
      if (!bus.addr_mode_i) mptr = (mptr + 1) % SL;
    end
    full = 1; any = 0;
    for (int k = 0; k < SL; k++) begin full &= mmask[k]; any |= mmask[k]; end
    if ((acc && full) || (fl && any)) begin
      w = '0; m = '0;
      for (int k = 0; k < SL; k++) if (mmask[k]) begin w[k*DW +: DW] = mdata[k]; m[k] = 1'b1; end
      expd.push_back(w);
      expm.push_back(m);
      pushed = 1;
      model_clear();
    end else if (fl) begin
      model_clear();
    end
    mfill = mfill + int'(pushed) - int'(pop);
  endtask

  task automatic cycle();
    @(posedge clk_i);
    if (rst_i) model_step();
    #1;
  endtask

  task automatic drive(bit v, logic [DW-1:0] d, bit m, int s, bit f, bit r);
    bus.in_valid_i  = v;
    bus.result_i    = d;
    bus.addr_mode_i = m;
    bus.slot_sel_i  = SW'(s);
    bus.flush_i     = f;
    bus.out_ready_i = r;
    cycle();
  endtask

  task automatic do_reset();
    #3 rst_i = 1'b0;
    model_clear();
    mfill = 0;
    expd.delete();
    expm.delete();
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_out_data", bus.out_data_o, 0);
    chk("rst_out_mask", bus.out_mask_o, 0);
    chk("rst_fill", bus.fill_o, 0);
    bus.in_valid_i = 0; bus.flush_i = 0; bus.out_ready_i = 1;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  // scoreboard monitor: compares status every cycle and the head whenever valid
  always @(negedge clk_i) begin
    chk("in_ready", bus.in_ready_o, mfill < DEPTH);
    chk("fill", bus.fill_o, mfill);
    chk("out_valid", bus.out_valid_o, mfill != 0);
    if (bus.out_valid_o) begin
      if (expd.size() == 0) begin
        vectors++; errors++;
        $display("FAIL head: got valid word %h, expected no word", bus.out_data_o);
      end else begin
        chk("head_data", bus.out_data_o, expd[0]);
        chk("head_mask", bus.out_mask_o, expm[0]);
        if (bus.out_ready_i) begin
          void'(expd.pop_front());
          void'(expm.pop_front());
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_i && b16.out_valid_o) begin
      got16++;
      chk("w16_data", b16.out_data_o, 64'h0004_0003_0002_0001);
      chk("w16_mask", b16.out_mask_o, 64'hF);
    end
  end

  initial begin
    b16.in_valid_i = 0; b16.result_i = '0; b16.addr_mode_i = 0;
    b16.slot_sel_i = '0; b16.flush_i = 0; b16.out_ready_i = 1;
    wait (rst_i === 1'b1);
    for (int i = 1; i <= 4; i++) begin
      b16.in_valid_i = 1; b16.result_i = 16'(i);
      @(posedge clk_i); #1;
    end
    b16.in_valid_i = 0;
  end

  initial begin
    model_clear();
    bus.in_valid_i = 0; bus.result_i = '0; bus.addr_mode_i = 0;
    bus.slot_sel_i = '0; bus.flush_i = 0; bus.out_ready_i = 1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    chk("post_rst_ready", bus.in_ready_o, 1);

    // auto-mode pair
    drive(1, 32'h1111_1111, 0, 0, 0, 1);
    drive(1, 32'h2222_2222, 0, 0, 0, 1);
    chk("pair_data", bus.out_data_o, 64'h2222_2222_1111_1111);
    chk("pair_mask", bus.out_mask_o, 2'b11);
    repeat (3) drive(0, 0, 0, 0, 0, 1);

    // addressed overwrite then flush
    drive(1, 32'hAAAA_0000, 1, 1, 0, 1);
    drive(1, 32'hBBBB_0000, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("ovw_data", bus.out_data_o, 64'hBBBB_0000_0000_0000);
    chk("ovw_mask", bus.out_mask_o, 2'b10);
    repeat (2) drive(0, 0, 0, 0, 0, 1);

    // fill the FIFO with the consumer stalled
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'hC000_0000 + i, 0, 0, 0, 0);
      if (i == 3) begin
        chk("full_fill", bus.fill_o, 2);
        chk("full_ready", bus.in_ready_o, 0);
      end
    end
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    drive(1, 32'hD000_0000, 0, 0, 0, 1);
    drive(1, 32'hD000_0001, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 1);

    // input merged with a flush, then flush on empty
    drive(1, 32'h5, 0, 0, 1, 1);
    chk("mflush_data", bus.out_data_o, 64'h5);
    chk("mflush_mask", bus.out_mask_o, 2'b01);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("eflush_none", bus.out_valid_o, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 1);

    // async reset mid-word, then a fresh pair starts at lane 0
    drive(1, 32'h7777_7777, 0, 0, 0, 1);
    do_reset();
    drive(1, 32'h1234_5678, 0, 0, 0, 1);
    drive(1, 32'h9ABC_DEF0, 0, 0, 0, 1);
    chk("post_rst_pair", bus.out_data_o, 64'h9ABC_DEF0_1234_5678);
    repeat (2) drive(0, 0, 0, 0, 0, 1);

    // randomised traffic with varying consumer back-pressure
    for (int i = 0; i < 3000; i++) begin
      int rbias;
      rbias = (i < 1000) ? 3 : ((i < 2000) ? 1 : 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, SL - 1)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) < rbias + 1);
    end

    repeat (8) drive(0, 0, 0, 0, 0, 1);
    chk("drain_empty", expd.size(), 0);
    chk("w16_count", got16, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
